ipc_mailbox_arbiter: RTL and testbench
======================================

IPC_MAILBOX_ARBITER -- requirements
Module: ipc_mailbox_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of requesting cores, legal range 2..4.
REQ-002 Parameter DATA_W, default 14: message width, equal to the core peripheral port width.
REQ-003 Parameter TIMEOUT_CYC, default 255: stall limit in cycles, used only under ARB_TIMEOUT_EN.
REQ-004 Clock_pin  in  1  single clock; all state changes on the rising edge.
REQ-005 Resetn_pin  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  NUM_REQ  per-requester message request level.
REQ-007 req_data  in  NUM_REQ*DATA_W  per-requester message; slice i occupies bits [i*DATA_W +: DATA_W].
REQ-008 req_done  out  NUM_REQ  per-requester completion level.
REQ-009 dst_valid  out  1  message present toward the consuming core.
REQ-010 dst_data  out  DATA_W  registered message toward the consumer.
REQ-011 dst_ack  in  1  consumer acknowledge level.
REQ-012 grant_id  out  2  index of the current or last granted requester.
REQ-013 busy  out  1  high in every state other than IDLE.
REQ-014 timeout_err  out  1  sticky stall flag; tied to 0 without ARB_TIMEOUT_EN.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, SEND, WAIT_LOW and DONE.
REQ-016 In IDLE with any req_valid high, the next edge SHALL:
- latch the winner's req_data into dst_data,
- set grant_id to the winner,
- set dst_valid = 1,
- enter SEND.
This gives one cycle of latency from req_valid to dst_valid.
REQ-017 Arbitration SHALL be round-robin. The search starts at rr_ptr and wraps modulo NUM_REQ. rr_ptr SHALL update to (grant+1) mod NUM_REQ when DONE is entered.
REQ-018 In SEND, on the first edge where dst_ack = 1, the block SHALL clear dst_valid and enter WAIT_LOW.
REQ-019 In WAIT_LOW, on the first edge where dst_ack = 0, the block SHALL enter DONE with req_done[grant_id] = 1.
REQ-020 In DONE, req_done[grant_id] SHALL hold at 1 until req_valid[grant_id] is sampled 0. The block SHALL then clear req_done and enter IDLE.
REQ-021 At most one req_done bit SHALL be high at any time. dst_data SHALL remain stable while dst_valid = 1.
REQ-022 req_valid or req_data changes from non-granted requesters SHALL have no effect outside IDLE.
REQ-023 dst_ack already high on entry to SEND SHALL count as the acknowledge, so WAIT_LOW is entered after one SEND cycle.
REQ-024 A requester whose req_valid stays high after its DONE SHALL be treated as a new request with rotated priority.

Reset
REQ-025 While Resetn_pin = 0, the block SHALL hold the following values:
- state = IDLE, rr_ptr = 0, grant_id = 0,
- dst_valid = 0, dst_data = 0, req_done = 0, busy = 0,
- timeout_err = 0, timeout counter = 0.
REQ-026 Reset asserted in any state SHALL abort the transfer with no completion reported.
REQ-027 The first edge after reset release SHALL perform normal IDLE evaluation.

Configuration
REQ-028 With ARB_TIMEOUT_EN defined, the block SHALL apply the following timeout behaviour:
- A counter SHALL clear on entry to SEND or WAIT_LOW and increment in each cycle spent in those states.
- When the counter reaches TIMEOUT_CYC, the block SHALL set dst_valid = 0 and timeout_err = 1, then enter DONE.
- timeout_err SHALL clear only on reset.
REQ-029 Without ARB_TIMEOUT_EN, the block SHALL contain no counter logic, timeout_err SHALL be constant 0, and SEND and WAIT_LOW SHALL wait indefinitely.

Structure
REQ-030 Package ipc_arb_pkg SHALL hold the FSM state type, the DATA_W default constant and the TIMEOUT_CYC default constant.
REQ-031 Round-robin selection SHALL be a sub-module, rr_priority_picker, with:
- inputs: request vector and rr_ptr,
- outputs: one-hot grant and any_req.

Verification
REQ-032 Single request: set req_valid = 3'b010 with slice 1 = 14'h0A5 -> the next cycle shows dst_valid = 1, dst_data = 14'h0A5 and grant_id = 1. Completing the ack and release handshakes -> req_done[1] = 1, then IDLE after req_valid[1] falls.
REQ-033 Contention: hold req_valid = 3'b111 with three back-to-back transfers -> grant order is 0, 1, 2. Starting again from 3'b111 -> requester 0 is granted first.
REQ-034 Early ack: hold dst_ack = 1 before the request -> SEND lasts exactly 1 cycle, and WAIT_LOW persists until dst_ack = 0.
REQ-035 Reset mid-transfer: assert Resetn_pin low while in WAIT_LOW -> all outputs are 0 immediately and rr_ptr = 0.
REQ-036 With ARB_TIMEOUT_EN, TIMEOUT_CYC = 8 and dst_ack held 0 -> dst_valid drops after 8 SEND cycles, timeout_err = 1 and req_done[grant] = 1.
REQ-037 Without ARB_TIMEOUT_EN and the same stimulus -> dst_valid stays at 1 for 1000 cycles and timeout_err = 0.

Source files
------------

// File: rtl/ipc_arb_pkg.sv
// Shared types and defaults for the IPC mailbox arbiter.
package ipc_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_LOW = 2'd2,
    ST_DONE     = 2'd3
  } arb_state_e;

  localparam int ARB_DATA_W_DEF      = 14;
  localparam int ARB_TIMEOUT_CYC_DEF = 255;

  // Round-robin successor of a requester index, wrapping at n.
  function automatic logic [1:0] rr_next(logic [1:0] g, int n);
    return (int'(g) == n - 1) ? 2'd0 : g + 2'd1;
  endfunction

endpackage

// File: rtl/ipc_mailbox_arbiter_rr_priority_picker.sv
// Round-robin priority picker: one-hot grant of the first active request
// found when searching upward from rr_ptr, wrapping modulo NUM_REQ.
module rr_priority_picker #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               any_req
);

  int idx;

  // Rotated first-one search; only the first hit is granted.
  always_comb begin
    gnt     = '0;
    idx     = 0;
    any_req = |req;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx] && (gnt == '0)) gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/ipc_mailbox_arbiter.sv
// IPC mailbox arbiter: round-robin selection of one requesting core, message
// forwarded to the consumer with a four-phase valid/ack and release handshake.
// Optional stall timeout is compiled in with the macro ARB_TIMEOUT_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no transfer; arbitrate among req_valid each edge
// SEND      | dst_valid high, waiting for dst_ack = 1
// WAIT_LOW  | message taken, waiting for dst_ack to return to 0
// DONE      | req_done[grant_id] high until the requester drops req_valid
module ipc_mailbox_arbiter
  import ipc_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int DATA_W      = ARB_DATA_W_DEF,
  parameter int TIMEOUT_CYC = ARB_TIMEOUT_CYC_DEF
) (
  input  logic                      Clock_pin,
  input  logic                      Resetn_pin,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      dst_valid,
  output logic [DATA_W-1:0]         dst_data,
  input  logic                      dst_ack,
  output logic [1:0]                grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  arb_state_e          state_q, state_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [1:0]          grant_q, grant_d;
  logic                dst_valid_q, dst_valid_d;
  logic [DATA_W-1:0]   dst_data_q, dst_data_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic                pick_any;
  logic [1:0]          pick_idx;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tmo_err_q, tmo_err_d;
  logic                tmo_hit;

  // The count after this cycle's increment would reach the limit.
  assign tmo_hit     = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign timeout_err = tmo_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_q),
    .gnt     (pick_gnt),
    .any_req (pick_any)
  );

  // One-hot grant to requester index.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) pick_idx = 2'(i);
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
    if (!Resetn_pin) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      dst_valid_q <= 1'b0;
      dst_data_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
      tmo_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      dst_valid_q <= dst_valid_d;
      dst_data_q  <= dst_data_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      tmo_err_q   <= tmo_err_d;
`endif
    end
  end

  // Next-state and datapath updates; rr_ptr rotates when DONE is entered.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    dst_valid_d = dst_valid_q;
    dst_data_d  = dst_data_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = '0;
    tmo_err_d   = tmo_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d     = pick_idx;
          dst_data_d  = req_data[pick_idx*DATA_W +: DATA_W];
          dst_valid_d = 1'b1;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
`ifdef ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (dst_ack) begin
          dst_valid_d = 1'b0;
          state_d     = ST_WAIT_LOW;
`ifdef ARB_TIMEOUT_EN
          cnt_d       = '0;
        end else if (tmo_hit) begin
          dst_valid_d = 1'b0;
          tmo_err_d   = 1'b1;
          rr_ptr_d    = rr_next(grant_q, NUM_REQ);
          state_d     = ST_DONE;
`endif
        end
      end
      ST_WAIT_LOW: begin
`ifdef ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (!dst_ack) begin
          rr_ptr_d = rr_next(grant_q, NUM_REQ);
          state_d  = ST_DONE;
`ifdef ARB_TIMEOUT_EN
        end else if (tmo_hit) begin
          tmo_err_d = 1'b1;
          rr_ptr_d  = rr_next(grant_q, NUM_REQ);
          state_d   = ST_DONE;
`endif
        end
      end
      ST_DONE: begin
        if (!req_valid[grant_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    req_done = '0;
    busy     = (state_q != ST_IDLE);
    if (state_q == ST_DONE) req_done[grant_q] = 1'b1;
  end

  assign dst_valid = dst_valid_q;
  assign dst_data  = dst_data_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_ipc_mailbox_arbiter.sv
// Self-checking bench for ipc_mailbox_arbiter: directed vector table,
// hand-written corner sequences and a randomized run against a
// transaction-level round-robin model.
module tb_ipc_mailbox_arbiter;

  localparam int N = 3;
  localparam int W = 14;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_done;
  logic           dst_valid;
  logic [W-1:0]   dst_data;
  logic           dst_ack = 1'b0;
  logic [1:0]     grant_id;
  logic           busy;
  logic           timeout_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0]   rv;
    logic [N*W-1:0] data;
    int             exp_g;
    logic [W-1:0]   exp_d;
  } vec_t;

  vec_t tbl[7];

  ipc_mailbox_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYC(8)) dut (
    .Clock_pin   (clk),
    .Resetn_pin  (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_done    (req_done),
    .dst_valid   (dst_valid),
    .dst_data    (dst_data),
    .dst_ack     (dst_ack),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    dst_ack   = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  function automatic logic [N*W-1:0] pack3(logic [W-1:0] s0, logic [W-1:0] s1, logic [W-1:0] s2);
    return {s2, s1, s0};
  endfunction

  // Reference: first valid requester scanning upward from p, wrapping.
  function automatic int rr_expect(logic [N-1:0] v, int p);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (p + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic do_xfer(input logic [N-1:0] rv, input logic [N*W-1:0] d,
                         input int eg, input logic [W-1:0] ed, input string tag);
    req_valid = rv;
    req_data  = d;
    tick();
    chk({tag, "_valid"}, dst_valid, 1);
    chk({tag, "_grant"}, grant_id, eg);
    chk({tag, "_data"}, dst_data, ed);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_done_early"}, req_done, 0);
    dst_ack = 1'b1;
    tick();
    chk({tag, "_valid_clr"}, dst_valid, 0);
    dst_ack = 1'b0;
    tick();
    chk({tag, "_done"}, req_done, 1 << eg);
    req_valid = '0;
    tick();
    chk({tag, "_done_clr"}, req_done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!dst_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, dst_valid, 1);
  endtask

  initial begin : main
    int m_ptr, m_grant, e, n_grants, cnt;
    logic prev_valid;
    logic [N-1:0] prev_done;
    logic [W-1:0] held;
    logic ok;

    tbl[0] = '{3'b010, pack3(14'h0111, 14'h00A5, 14'h0222), 1, 14'h00A5};
    tbl[1] = '{3'b011, pack3(14'h3FFF, 14'h1234, 14'h0001), 0, 14'h3FFF};
    tbl[2] = '{3'b101, pack3(14'h0AAA, 14'h1555, 14'h2AAA), 2, 14'h2AAA};
    tbl[3] = '{3'b110, pack3(14'h0000, 14'h3000, 14'h0FFF), 1, 14'h3000};
    tbl[4] = '{3'b100, pack3(14'h0001, 14'h0002, 14'h0003), 2, 14'h0003};
    tbl[5] = '{3'b001, pack3(14'h2BCD, 14'h0000, 14'h0000), 0, 14'h2BCD};
    tbl[6] = '{3'b111, pack3(14'h0010, 14'h0020, 14'h0030), 1, 14'h0020};

    // Values held during reset.
    rst_n = 1'b0;
    tick();
    chk("rst_valid", dst_valid, 0);
    chk("rst_data", dst_data, 0);
    chk("rst_done", req_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_tmo", timeout_err, 0);
    do_reset();

    // Directed table: each entry is a full transfer; pointer carries over.
    for (int i = 0; i < 7; i++) begin
      do_xfer(tbl[i].rv, tbl[i].data, tbl[i].exp_g, tbl[i].exp_d, $sformatf("tbl%0d", i));
    end

    // Contention: 0,1,2 then 0 again.
    do_reset();
    req_valid = 3'b111;
    req_data  = pack3(14'h0100, 14'h0200, 14'h0300);
    for (int k = 0; k < 4; k++) begin
      wait_valid($sformatf("cont%0d", k));
      chk($sformatf("cont%0d_grant", k), grant_id, k % 3);
      dst_ack = 1'b1;
      tick();
      dst_ack = 1'b0;
      tick();
      chk($sformatf("cont%0d_done", k), req_done, 1 << (k % 3));
      req_valid[k % 3] = 1'b0;
      tick();
      if (k < 3) req_valid = 3'b111;
    end
    req_valid = '0;
    tick();

    // Early ack: one SEND cycle, WAIT_LOW holds while ack stays high.
    do_reset();
    dst_ack = 1'b1;
    tick();
    req_valid = 3'b001;
    req_data  = pack3(14'h0007, 14'h0008, 14'h0009);
    tick();
    chk("early_send", dst_valid, 1);
    tick();
    chk("early_send_1cyc", dst_valid, 0);
    chk("early_busy", busy, 1);
    ok = 1'b1;
    repeat (5) begin
      tick();
      if (req_done !== '0 || busy !== 1'b1) ok = 1'b0;
    end
    chk("early_waitlow_hold", ok, 1);
    dst_ack = 1'b0;
    tick();
    chk("early_done", req_done, 3'b001);
    req_valid = '0;
    tick();

    // Reset in WAIT_LOW with rr_ptr already advanced to 2.
    do_reset();
    do_xfer(3'b010, pack3(14'h0001, 14'h0002, 14'h0003), 1, 14'h0002, "pre_rst");
    req_valid = 3'b100;
    tick();
    dst_ack = 1'b1;
    tick();
    chk("mid_waitlow", dst_valid, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", dst_valid, 0);
    chk("mid_rst_data", dst_data, 0);
    chk("mid_rst_done", req_done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_grant", grant_id, 0);
    req_valid = 3'b111;
    dst_ack   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", dst_valid, 1);
    chk("post_rst_grant", grant_id, 0);
    dst_ack = 1'b1;
    tick();
    dst_ack = 1'b0;
    tick();
    chk("post_rst_done", req_done, 3'b001);
    req_valid = '0;
    tick();

    // Randomized run against the transaction model.
    do_reset();
    m_ptr = 0;
    m_grant = 0;
    n_grants = 0;
    prev_valid = 1'b0;
    prev_done = '0;
    held = '0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($countones(req_done) > 1) chk("rnd_done_onehot", req_done, 1 << m_grant);
      if (req_done !== '0 && prev_done === '0) begin
        chk("rnd_done", req_done, 1 << m_grant);
        m_ptr = (m_grant + 1) % N;
      end
      if (dst_valid && !prev_valid) begin
        e = rr_expect(req_valid, m_ptr);
        chk("rnd_grant", grant_id, e);
        if (e < 0) e = 0;
        chk("rnd_data", dst_data, req_data[e*W +: W]);
        m_grant = e;
        held = req_data[e*W +: W];
        n_grants++;
      end else if (dst_valid) begin
        if (dst_data !== held) chk("rnd_data_stable", dst_data, held);
      end
      prev_valid = dst_valid;
      prev_done  = req_done;
      for (int i = 0; i < N; i++) begin
        if (req_done[i]) begin
          if ($urandom_range(1, 0) == 1) req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(3, 0) == 0) begin
          req_valid[i] = 1'b1;
        end
        if ($urandom_range(3, 0) == 0) req_data[i*W +: W] = 14'($urandom);
      end
      dst_ack = 1'($urandom_range(1, 0));
    end
    chk("rnd_progress", n_grants > 50, 1);

    // Stall behaviour with dst_ack held low.
    do_reset();
    req_valid = 3'b010;
`ifdef ARB_TIMEOUT_EN
    tick();
    cnt = 0;
    while (dst_valid && cnt < 20) begin
      cnt++;
      tick();
    end
    chk("tmo_send_cycles", cnt, 8);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_done", req_done, 3'b010);
    req_valid = '0;
    tick();
    chk("tmo_idle", busy, 0);
    chk("tmo_sticky", timeout_err, 1);
`else
    tick();
    ok = 1'b1;
    cnt = 0;
    repeat (1000) begin
      if (!dst_valid || timeout_err) ok = 1'b0;
      cnt++;
      tick();
    end
    chk("notmo_hold", ok, 1);
    chk("notmo_err", timeout_err, 0);
    dst_ack = 1'b1;
    tick();
    dst_ack = 1'b0;
    tick();
    chk("notmo_done", req_done, 3'b010);
    req_valid = '0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
